// File: rtl/mask_bool_decoder.sv
// mask_bool_decoder: decodes replicated boolean mask words through a 2-entry skid buffer with a saturating malformed-word counter.
// Define MASK_BOOL_DECODER_DROP_MALFORMED_EN to count but discard malformed words instead of forwarding them.
module mask_bool_decoder #(
    parameter int MASK_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MASK_W-1:0] din_data,
    input  logic              din_vld,
    output logic              din_rd,
    output logic              dout_data,
    output logic              dout_err,
    output logic              dout_vld,
    input  logic              dout_rd,
    output logic [CNT_W-1:0]  err_cnt,
    input  logic              clr_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t state, state_nxt;
    logic head_d, head_e, tail_d, tail_e;
    logic in_d, in_e, acc, wr, dlv;
    assign in_d = din_data[MASK_W-1];
    assign in_e = ~(&din_data) & (|din_data);
    assign acc = din_vld & din_rd;
    assign dlv = dout_vld & dout_rd;
    assign dout_vld = state != EMPTY;
    assign dout_data = head_d;
`ifdef MASK_BOOL_DECODER_DROP_MALFORMED_EN
    assign wr = acc & ~in_e;
    assign dout_err = 1'b0;
`else
    assign wr = acc;
    assign dout_err = head_e;
`endif
    always_comb begin
        state_nxt = state;
        if (state == EMPTY)
            state_nxt = wr ? ONE : EMPTY;
        else if (state == ONE)
            state_nxt = (wr && !dlv) ? TWO : (!wr && dlv) ? EMPTY : ONE;
        else
            state_nxt = dlv ? ONE : TWO;
    end
    // head takes the incoming word unless it must queue behind an undelivered head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            din_rd  <= 1'b0;
            head_d  <= 1'b0;
            head_e  <= 1'b0;
            tail_d  <= 1'b0;
            tail_e  <= 1'b0;
            err_cnt <= '0;
        end else begin
            state  <= state_nxt;
            din_rd <= state_nxt != TWO;
            if (state == TWO && dlv) begin
                head_d <= tail_d;
                head_e <= tail_e;
            end else if (wr && (state != ONE || dlv)) begin
                head_d <= in_d;
                head_e <= in_e;
            end
            if (wr && state == ONE && !dlv) begin
                tail_d <= in_d;
                tail_e <= in_e;
            end
            err_cnt <= clr_cnt ? CNT_W'(acc & in_e)
                     : (acc && in_e && err_cnt != CNT_MAX) ? err_cnt + CNT_W'(1) : err_cnt;
        end
    end
endmodule

// File: tb/tb_mask_bool_decoder.sv
// tb_mask_bool_decoder: vector table, directed corner sequences and random traffic checked against a queue-based model.
module tb_mask_bool_decoder;
    localparam int MASK_W = 3;
    localparam int CNT_W  = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [MASK_W-1:0] din_data;
    logic din_vld, din_rd, dout_data, dout_err, dout_vld, dout_rd, clr_cnt;
    logic [CNT_W-1:0] err_cnt;
    mask_bool_decoder #(.MASK_W(MASK_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .din_data(din_data), .din_vld(din_vld), .din_rd(din_rd),
        .dout_data(dout_data), .dout_err(dout_err), .dout_vld(dout_vld), .dout_rd(dout_rd),
        .err_cnt(err_cnt), .clr_cnt(clr_cnt)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [MASK_W-1:0] w;
        logic d;
        logic e;
    } vec_t;
    vec_t tbl[9];
    int checks = 0;
    int errors = 0;
    logic [1:0] q[$];
    logic mrd;
    logic [CNT_W-1:0] mcnt;
    logic acc;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic model_reset();
        q.delete();
        mrd = 1'b0;
        mcnt = '0;
    endtask
    // compare against the model, advance one clock, then update the model
    task automatic step();
        logic mal, dlv;
        mal = (din_data != 3'b000) && (din_data != 3'b111);
        chk("din_rd", din_rd, mrd);
        chk("dout_vld", dout_vld, q.size() != 0);
        if (q.size() != 0) begin
            chk("dout_data", dout_data, q[0][1]);
            chk("dout_err", dout_err, q[0][0]);
        end
        chk("err_cnt", err_cnt, mcnt);
        acc = din_vld && mrd;
        dlv = dout_rd && q.size() != 0;
        @(posedge clk);
        #1;
        if (dlv) void'(q.pop_front());
        if (acc) q.push_back({din_data[MASK_W-1], mal});
        mcnt = clr_cnt ? CNT_W'(acc && mal) : (acc && mal && mcnt != '1) ? mcnt + CNT_W'(1) : mcnt;
        mrd = q.size() < 2;
    endtask
    initial begin
        logic [MASK_W-1:0] bp[3];
        int n, k;
        tbl[0] = '{3'b000, 1'b0, 1'b0};
        tbl[1] = '{3'b111, 1'b1, 1'b0};
        tbl[2] = '{3'b111, 1'b1, 1'b0};
        tbl[3] = '{3'b010, 1'b0, 1'b1};
        tbl[4] = '{3'b110, 1'b1, 1'b1};
        tbl[5] = '{3'b001, 1'b0, 1'b1};
        tbl[6] = '{3'b100, 1'b1, 1'b1};
        tbl[7] = '{3'b011, 1'b0, 1'b1};
        tbl[8] = '{3'b101, 1'b1, 1'b1};
        bp[0] = 3'b111;
        bp[1] = 3'b000;
        bp[2] = 3'b111;
        din_vld = 1'b0;
        din_data = '0;
        dout_rd = 1'b0;
        clr_cnt = 1'b0;
        model_reset();
        #2;
        chk("rst_din_rd", din_rd, 0);
        chk("rst_dout_vld", dout_vld, 0);
        chk("rst_dout_data", dout_data, 0);
        chk("rst_dout_err", dout_err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("release_din_rd", din_rd, 0);
        dout_rd = 1'b1;
        for (int i = 0; i < 9; i++) begin
            din_vld = 1'b1;
            din_data = tbl[i].w;
            n = 0;
            do begin
                step();
                n++;
            end while (!acc && n < 10);
            chk("tbl_tput", n, (i == 0) ? 2 : 1);
            chk("tbl_vld", dout_vld, 1);
            chk("tbl_data", dout_data, tbl[i].d);
            chk("tbl_err", dout_err, tbl[i].e);
        end
        din_vld = 1'b0;
        repeat (2) step();
        chk("tbl_cnt", err_cnt, 6);
        k = 0;
        for (int c = 0; c < 40; c++) begin
            din_vld = k < 3;
            din_data = bp[k % 3];
            dout_rd = c >= 6;
            step();
            if (acc) k++;
            if (c == 1) begin
                chk("bp_full_rd", din_rd, 0);
                chk("bp_full_vld", dout_vld, 1);
                chk("bp_full_head", dout_data, 1);
            end
        end
        chk("bp_all_accepted", k, 3);
        chk("bp_drained", dout_vld, 0);
        chk("bp_rd_back", din_rd, 1);
        din_vld = 1'b0;
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        chk("clr_alone", err_cnt, 0);
        din_vld = 1'b1;
        dout_rd = 1'b1;
        din_data = 3'b010;
        repeat (262) step();
        din_vld = 1'b0;
        step();
        chk("sat", err_cnt, 255);
        din_vld = 1'b1;
        din_data = 3'b110;
        clr_cnt = 1'b1;
        step();
        chk("clr_acc_taken", acc, 1);
        clr_cnt = 1'b0;
        din_vld = 1'b0;
        chk("clr_with_acc", err_cnt, 1);
        for (int c = 0; c < 10000; c++) begin
            din_vld = $urandom_range(0, 1) != 0;
            dout_rd = $urandom_range(0, 3) != 0;
            din_data = ($urandom_range(0, 1) != 0) ? (($urandom_range(0, 1) != 0) ? 3'b111 : 3'b000) : 3'($urandom);
            clr_cnt = $urandom_range(0, 499) == 0;
            step();
        end
        clr_cnt = 1'b0;
        din_vld = 1'b0;
        dout_rd = 1'b1;
        repeat (3) step();
        chk("rand_drain", dout_vld, 0);
        dout_rd = 1'b0;
        din_vld = 1'b1;
        din_data = 3'b111;
        n = 0;
        while (mrd && n < 10) begin
            step();
            n++;
        end
        chk("two_rd", din_rd, 0);
        chk("two_vld", dout_vld, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_vld", dout_vld, 0);
        chk("async_rd", din_rd, 0);
        chk("async_cnt", err_cnt, 0);
        model_reset();
        @(posedge clk);
        #1;
        din_vld = 1'b0;
        rst = 1'b0;
        dout_rd = 1'b1;
        repeat (4) step();
        chk("post_rst_empty", dout_vld, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mask_bool_decoder.md
Name: mask_bool_decoder

Overview:
Receiving end of the boolean replication path. Upstream comparators send a 1-bit result replicated or sign-extended into a MASK_W-bit word. This block turns each word back into a single boolean and flags malformed words, where not all bits are equal. It sits behind a valid/ready stream, buffers up to two results in a 2-entry skid buffer with a registered din_rd, and keeps a saturating error counter.

Parameters:
MASK_W, 3, width of incoming replicated mask word (>=1)
CNT_W, 8, width of malformed-word error counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-high
din_data  in  MASK_W  replicated boolean word
din_vld  in  1  din_data valid
din_rd  out  1  block can accept a word (registered)
dout_data  out  1  decoded boolean
dout_err  out  1  word carried in dout_data was malformed
dout_vld  out  1  dout_data/dout_err valid
dout_rd  in  1  downstream accepts
err_cnt  out  CNT_W  count of malformed words accepted, saturating
clr_cnt  in  1  synchronous clear of err_cnt

Behaviour:
- Reset values (asserted, async): state=EMPTY, din_rd=0, dout_vld=0, dout_data=0, dout_err=0, err_cnt=0.
- Word accepted on a clock edge where din_vld && din_rd. Word delivered on an edge where dout_vld && dout_rd.
- Decode: data = din_data[MASK_W-1], the sign bit. err = 1 unless din_data is all-0 or all-1. With MASK_W=1, err is always 0.
- Buffer: 2 entries, FIFO order, head drives dout_*. dout_vld=1 when state!=EMPTY.
- State EMPTY:
  - accept -> ONE.
- State ONE:
  - accept only -> TWO.
  - deliver only -> EMPTY.
  - both -> ONE, with the new word as head.
- State TWO:
  - deliver -> ONE. The second entry becomes head on the next cycle.
  - No accept is possible, since din_rd=0.
- din_rd is a flop.
  - Next value = 1 when next state != TWO.
  - First edge after rst release sets din_rd=1.
  - After reset release, din_rd=0 for exactly one cycle.
- Latency: a word accepted at edge N is visible on dout_* after edge N when the buffer was EMPTY.
- Throughput: 1 word/cycle sustained while dout_rd=1.
- err_cnt:
  - +1 per accepted malformed word.
  - Saturates at 2^CNT_W-1, no wrap.
  - clr_cnt has priority as a clear. clr_cnt together with a malformed accept in the same cycle gives err_cnt=1; clr_cnt alone gives 0.
- dout_vld=1 && dout_rd=0: dout_data and dout_err stay stable until delivered.
- Reset mid-operation: buffered entries are discarded, no partial output. din_rd drops asynchronously with rst.

Optional Feature:
Macro MASK_BOOL_DECODER_DROP_MALFORMED_EN.
- Defined: malformed words are still accepted (handshake completes) and counted in err_cnt, but are not written to the buffer and never appear on dout. dout_err is tied to 0. The state transition for that accept is treated as no-accept.
- Undefined: malformed words are forwarded with dout_err=1 and data=MSB, as described above.

Test Plan:
- Reset, then release, dout_rd=1, stream 3'b000, 3'b111, 3'b111 back-to-back -> din_rd=0 for the first post-reset cycle, then dout_data 0,1,1 on consecutive cycles with dout_err=0; err_cnt=0.
- dout_rd=0, drive 3 valid words -> first two accepted, din_rd=0 one cycle after the second accept, state TWO. Raise dout_rd -> outputs emerge in order and din_rd returns to 1.
- Send 3'b010, then 3'b110 -> dout_data=0, dout_err=1, then dout_data=1, dout_err=1; err_cnt=2. With the DROP macro defined: no dout_vld, err_cnt=2.
- CNT_W=2: send 5 malformed words -> err_cnt saturates at 3. Pulse clr_cnt in the same cycle as a malformed accept -> err_cnt=1.
- Random din_vld and dout_rd for 10k cycles, mixed words -> scoreboard order, data and err match, no word lost or duplicated, err_cnt equals malformed count (capped at saturation).
- Assert rst while the buffer is in TWO -> dout_vld=0 and din_rd=0 immediately (async). After release, no stale word appears on dout.
